snd_dsm_out: RTL and testbench
==============================

Name: snd_dsm_out

Overview:
Audio output stage that sits directly downstream of the oscillator/sample generator and drives the 1-bit sound pin.
- Buffers signed PCM samples arriving on a valid/ready stream in a small FIFO.
- Consumes one sample per fixed sample period.
- Applies a click-free gain ramp for soft start and mute.
- Converts the result to a 1-bit pulse-density stream with a first-order delta-sigma modulator.

Parameters:
- W, 12: sample width, two's complement.
- FIFO_DEPTH, 4: FIFO entries; power of 2, at least 2.
- SAMPLE_DIV, 1024: clk cycles per consumed sample; at least 4.

Ports:
- clk  in  1: pixel/system clock.
- rst_n  in  1: reset, asynchronous, active-low.
- s_valid  in  1: upstream sample valid.
- s_ready  out  1: FIFO can accept a sample.
- s_data  in  W: signed sample.
- mute  in  1: 1 ramps gain to 0; 0 ramps gain to full.
- clear_underrun  in  1: clears the sticky underrun flag.
- underrun  out  1: sticky; FIFO was empty at a sample tick.
- snd  out  1: registered delta-sigma output bit.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FIFO empty; s_ready=0 while rst_n=0 and 1 from the first clk after release.
  - cur=0, gain=0, eff_r=0, acc=0, div counter=0, snd=0, underrun=0.
- Handshake:
  - Push occurs when s_valid & s_ready.
  - s_ready = ~full. A pop in the same cycle does not make a full FIFO accept.
  - s_data must be held while s_valid & ~s_ready.
- Tick:
  - div counter runs 0..SAMPLE_DIV-1 and wraps.
  - tick is asserted when the counter equals SAMPLE_DIV-1.
- On tick, sample path:
  - FIFO not empty: pop; cur <= head.
  - FIFO empty: cur holds its value; underrun <= 1.
  - A push in the same cycle as a tick on an empty FIFO is not visible to that tick. It is an underrun, and the pushed sample is popped at the next tick.
- On tick, gain:
  - gain is 5 bits, range 0..16.
  - mute=0 and gain<16: gain+1. mute=1 and gain>0: gain-1. Otherwise gain holds.
  - A mute change mid-ramp reverses direction at the next tick.
  - Full ramp takes 16 ticks. Soft start is inherent because gain resets to 0.
- Underrun flag:
  - clear_underrun=1 clears underrun.
  - Set has priority over clear in the same cycle.
- Scaling (every cycle):
  - eff = (cur * gain) >>> 4, arithmetic shift, computed at W+6 bits.
  - Result is truncated to W bits; gain=16 gives exactly cur.
  - eff_r <= eff; this is 1 cycle of latency.
- Modulator (every cycle):
  - u = eff_r + 2^(W-1) taken as unsigned W bits, i.e. eff_r with the MSB inverted.
  - {c, acc} <= acc + u, with acc W bits wide; snd <= c.
  - Ones density over 2^W cycles is exactly u/2^W for constant u.
- Latency: tick → cur/gain updated at +1, eff_r at +2, first affected snd bit at +3.
- No state machine beyond the ramp. The ramp states are implicit in gain:
  - MUTED: gain=0.
  - RAMPING: 0<gain<16.
  - FULL: gain=16.

Decomposition:
- Package snd_pkg holds:
  - GAIN_BITS=5 and GAIN_MAX=16.
  - The shift constant GAIN_SHIFT=4.
  - The sample-offset helper function (MSB invert).
- Sub-module snd_fifo: synchronous FIFO, parameterised by W and FIFO_DEPTH.
  - Pointers are log2(DEPTH)+1 bits wide.
  - Outputs: full, empty, head.
  - Same asynchronous active-low reset.

Test Plan:
1. Reset: hold rst_n=0 mid-run → snd=0, s_ready=0, underrun=0 immediately; after release s_ready=1 on the next clk, gain=0.
2. Fill (W=12, FIFO_DEPTH=4, SAMPLE_DIV=8, s_valid held high):
   - 4 samples accepted on consecutive cycles.
   - s_ready=0 after the 4th.
   - One slot frees per tick; a new accept follows each tick.
3. Density:
   - After ramp complete (gain=16), constant sample 0 → snd alternates 0/1, exactly 2048 ones in 4096 cycles.
   - Sample +1024 → 3072 ones in 4096 cycles.
   - Sample -2048 → snd constant 0.
4. Soft start: stream +2047, mute=0 from reset → gain reads 0,1,…,16 at successive ticks and saturates at 16; eff_r at gain=8 equals 1023.
5. Underrun:
   - No pushes → underrun=1 after the first tick while cur holds.
   - clear_underrun pulse → 0.
   - clear_underrun coincident with an underrun tick → stays 1.
6. Mute:
   - At gain=16 with sample +2047, assert mute → gain decrements per tick to 0; density converges to 50%.
   - Deassert mute at gain=5 → next tick gain=6.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared constants and helpers for the 1-bit delta-sigma sound output stage.
package snd_pkg;

  localparam int GAIN_BITS  = 5;
  localparam int GAIN_MAX   = 16;
  localparam int GAIN_SHIFT = 4;

  // Two's complement to offset binary: flipping bit w-1 adds 2^(w-1) modulo 2^w.
  function automatic logic [31:0] pcm_to_offset(input logic [31:0] x, input int unsigned w);
    pcm_to_offset = x ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/snd_fifo.sv
// Small synchronous FIFO for PCM samples. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate occupancy counter.
module snd_fifo
  import snd_pkg::*;
#(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Advance read and write pointers on accepted pushes and pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sample storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/snd_dsm_out.sv
// Audio output stage: buffers PCM samples, consumes one per sample period,
// applies a 0..16 gain ramp for click-free start/mute, and drives the sound
// pin through a first-order delta-sigma modulator.
// The ramp has no explicit state register: gain=0 is muted, 16 is full,
// anything between is ramping.
module snd_dsm_out
  import snd_pkg::*;
#(
  parameter int W          = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_DIV = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  input  logic         mute,
  input  logic         clear_underrun,
  output logic         underrun,
  output logic         snd
);

  localparam int DIV_BITS = $clog2(SAMPLE_DIV);
  localparam logic [DIV_BITS-1:0]  DIV_LAST  = DIV_BITS'(SAMPLE_DIV - 1);
  localparam logic [GAIN_BITS-1:0] GAIN_FULL = GAIN_BITS'(GAIN_MAX);

  logic [DIV_BITS-1:0]  div_cnt;
  logic                 tick;
  logic                 rdy_en;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [W-1:0]         fifo_head;
  logic                 push;
  logic                 pop;
  logic [W-1:0]         cur;
  logic [GAIN_BITS-1:0] gain;
  logic signed [W+5:0]  prod;
  logic signed [W+5:0]  prod_sh;
  logic [W-1:0]         eff;
  logic [W-1:0]         eff_r;
  logic [W-1:0]         u;
  logic [W:0]           acc_sum;
  logic [W-1:0]         acc;
  logic                 unused_prod_bits;

  assign tick    = (div_cnt == DIV_LAST);
  assign s_ready = rdy_en & ~fifo_full;
  assign push    = s_valid & s_ready;
  // The FIFO's registered empty flag means a push landing on the tick edge
  // cannot be popped by that same tick.
  assign pop     = tick & ~fifo_empty;

  snd_fifo #(
    .W     (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (s_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Keep s_ready low through reset and enable it from the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Sample-period divider, free running 0..SAMPLE_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Current sample: load the FIFO head on a tick, otherwise hold (also on underrun).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cur <= '0;
    else if (pop) cur <= fifo_head;
  end

  // Gain ramp: one step per tick toward full or toward zero depending on mute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain <= '0;
    end else if (tick) begin
      if (!mute && (gain < GAIN_FULL))  gain <= gain + 1'b1;
      else if (mute && (gain != '0))    gain <= gain - 1'b1;
    end
  end

  // Sticky underrun: setting on an empty tick wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      underrun <= 1'b0;
    else if (tick && fifo_empty)     underrun <= 1'b1;
    else if (clear_underrun)         underrun <= 1'b0;
  end

  // Scale by gain/16 at W+6 bits; gain=16 reproduces cur exactly after the shift.
  always_comb begin
    prod    = $signed({{6{cur[W-1]}}, cur}) * $signed({{(W+1){1'b0}}, gain});
    prod_sh = prod >>> GAIN_SHIFT;
    eff     = prod_sh[W-1:0];
  end

  assign unused_prod_bits = ^prod_sh[W+5:W];

  // Register the scaled sample ahead of the modulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eff_r <= '0;
    else        eff_r <= eff;
  end

  // Modulator input in offset binary and the accumulator sum with its carry.
  always_comb begin
    u       = W'(pcm_to_offset(32'(eff_r), W));
    acc_sum = {1'b0, acc} + {1'b0, u};
  end

  // First-order delta-sigma: the accumulator carry is the output bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      snd <= 1'b0;
    end else begin
      acc <= acc_sum[W-1:0];
      snd <= acc_sum[W];
    end
  end

endmodule

// File: tb/tb_snd_dsm_out.sv
module tb_snd_dsm_out;

  localparam int W     = 12;
  localparam int DEPTH = 4;
  localparam int DIV   = 8;
  localparam int FS    = 1 << W;
  localparam int HALF  = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         mute = 1'b0;
  logic         clear_underrun = 1'b0;
  logic         underrun;
  logic         snd;

  always #5 clk = ~clk;

  snd_dsm_out #(
    .W          (W),
    .FIFO_DEPTH (DEPTH),
    .SAMPLE_DIV (DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .mute           (mute),
    .clear_underrun (clear_underrun),
    .underrun       (underrun),
    .snd            (snd)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: a queue of samples, integer gain and plain arithmetic.
  int m_q[$];
  int m_cur, m_gain, m_eff, m_acc, m_snd, m_und, m_div, m_rdy;
  bit m_tick, m_pushed;

  task automatic model_reset();
    m_q.delete();
    m_cur = 0; m_gain = 0; m_eff = 0; m_acc = 0; m_snd = 0;
    m_und = 0; m_div = 0; m_rdy = 0; m_tick = 0; m_pushed = 0;
  endtask

  function automatic int floor_div16(input int p);
    if (p >= 0) return p / 16;
    return -((-p + 15) / 16);
  endfunction

  task automatic model_step();
    int  sum;
    bit  tk, psh, was_empty;
    if (!rst_n) begin
      model_reset();
    end else begin
      psh       = s_valid && (m_rdy != 0) && (m_q.size() < DEPTH);
      tk        = (m_div == DIV - 1);
      was_empty = (m_q.size() == 0);
      sum       = m_acc + m_eff + HALF;
      m_snd     = (sum >= FS) ? 1 : 0;
      m_acc     = sum % FS;
      m_eff     = floor_div16(m_cur * m_gain);
      if (tk) begin
        if (!was_empty) m_cur = m_q.pop_front();
        if (!mute && m_gain < 16) m_gain++;
        else if (mute && m_gain > 0) m_gain--;
      end
      if (tk && was_empty)     m_und = 1;
      else if (clear_underrun) m_und = 0;
      if (psh) m_q.push_back(int'($signed(s_data)));
      m_div    = (m_div + 1) % DIV;
      m_rdy    = 1;
      m_tick   = tk;
      m_pushed = psh;
    end
  endtask

  task automatic compare_all();
    chk("snd",      int'(snd), m_snd);
    chk("s_ready",  int'(s_ready), ((m_rdy != 0) && (m_q.size() < DEPTH)) ? 1 : 0);
    chk("underrun", int'(underrun), m_und);
    chk("gain",     int'(dut.gain), m_gain);
    chk("cur",      int'($signed(dut.cur)), m_cur);
    chk("eff_r",    int'($signed(dut.eff_r)), m_eff);
  endtask

  // Source: constant or random samples, data held while stalled.
  bit src_en = 0;
  bit src_rand = 0;
  int src_val = 0;
  bit last_acc = 0;

  task automatic cycle();
    last_acc = s_valid && s_ready;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (!src_en) s_valid = 1'b0;
    else if (m_pushed || !s_valid) begin
      s_valid = 1'b1;
      s_data  = src_rand ? W'($urandom) : W'(src_val);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to_tick();
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!m_tick && n < 4 * DIV);
    if (!m_tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) run_to_tick();
  endtask

  task automatic run_to_pre_tick();
    int n = 0;
    while (m_div != DIV - 1 && n < 4 * DIV) begin
      cycle();
      n++;
    end
  endtask

  task automatic clear_pulse();
    clear_underrun = 1'b1;
    cycle();
    clear_underrun = 1'b0;
  endtask

  task automatic count_ones(input string tag, input int exp);
    int ones = 0;
    for (int i = 0; i < FS; i++) begin
      cycle();
      ones += int'(snd);
    end
    chk(tag, ones, exp);
  endtask

  task automatic density(input int val);
    src_val = val;
    run_ticks(8);
    run_cycles(3);
    count_ones("density", val + HALF);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    model_reset();
    #2;
    chk("rst_snd", int'(snd), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_underrun", int'(underrun), 0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    src_en  = 1;
    src_val = 2047;
    s_valid = 1'b1;
    s_data  = W'(src_val);

    // Release, then fill: four consecutive accepts, then stall.
    cycle();
    chk("rdy_after_release", int'(s_ready), 1);
    chk("gain_after_release", int'(dut.gain), 0);
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      acc_cnt += int'(last_acc);
    end
    chk("fill_accepts", acc_cnt, 4);
    chk("fill_full", int'(s_ready), 0);

    // One slot frees per tick, refilled on the next cycle; ramp steps alongside.
    for (int k = 1; k <= 20; k++) begin
      run_to_tick();
      chk("ramp_gain", int'(dut.gain), (k < 16) ? k : 16);
      if (k <= 2) begin
        chk("rdy_after_tick", int'(s_ready), 1);
        cycle();
        chk("accept_after_tick", int'(last_acc), 1);
        chk("full_again", int'(s_ready), 0);
      end
      if (k == 8) begin
        cycle();
        chk("eff_at_gain8", int'($signed(dut.eff_r)), 1023);
      end
    end

    density(0);
    density(1024);
    density(-2048);

    // Underrun behaviour with the source stopped.
    src_en = 0;
    run_ticks(8);
    clear_pulse();
    chk("und_cleared", int'(underrun), 0);
    run_to_tick();
    chk("und_set", int'(underrun), 1);
    chk("und_cur_hold", int'($signed(dut.cur)), -2048);
    clear_pulse();
    chk("und_clear_pulse", int'(underrun), 0);
    run_to_pre_tick();
    clear_underrun = 1'b1;
    cycle();
    clear_underrun = 1'b0;
    chk("und_set_beats_clear", int'(underrun), 1);

    // Push landing on an empty tick: underrun now, sample consumed next tick.
    clear_pulse();
    chk("und_cleared2", int'(underrun), 0);
    run_to_pre_tick();
    src_en  = 1;
    src_val = 500;
    s_valid = 1'b1;
    s_data  = W'(src_val);
    cycle();
    src_en = 0;
    chk("push_on_tick_und", int'(underrun), 1);
    chk("push_on_tick_cur", int'($signed(dut.cur)), -2048);
    clear_pulse();
    run_to_tick();
    chk("late_pop_cur", int'($signed(dut.cur)), 500);
    chk("late_pop_und", int'(underrun), 0);

    // Mute ramp down, reversal at gain 5, then full mute gives 50% density.
    src_en  = 1;
    src_val = 2047;
    run_ticks(8);
    chk("pre_mute_gain", int'(dut.gain), 16);
    mute = 1'b1;
    for (int g = 15; g >= 5; g--) begin
      run_to_tick();
      chk("mute_gain", int'(dut.gain), g);
    end
    mute = 1'b0;
    run_to_tick();
    chk("unmute_gain", int'(dut.gain), 6);
    mute = 1'b1;
    run_ticks(8);
    chk("muted_gain", int'(dut.gain), 0);
    run_cycles(3);
    count_ones("muted_density", HALF);

    // Randomised traffic, mute and clear activity.
    src_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) mute = ~mute;
      clear_underrun = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 4) src_en = ~src_en;
      cycle();
    end
    clear_underrun = 1'b0;

    // Asynchronous reset mid-run.
    rst_n = 1'b0;
    #1;
    chk("midrst_snd", int'(snd), 0);
    chk("midrst_s_ready", int'(s_ready), 0);
    chk("midrst_underrun", int'(underrun), 0);
    model_reset();
    run_cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    mute  = 1'b0;
    src_en = 1;
    cycle();
    chk("midrst_rdy_release", int'(s_ready), 1);
    chk("midrst_gain", int'(dut.gain), 0);
    run_cycles(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
